// File: rtl/canny_frame_sequencer_if.sv
// Valid/ready video beat stream with end-of-video marker, used for both the
// input side and the output side of canny_frame_sequencer.
interface canny_frame_sequencer_if #(
    parameter int DATA_W = 24
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              eop;

    modport master (output valid, output data, output eop, input ready);
    modport slave  (input valid, input data, input eop, output ready);
endinterface

// File: rtl/canny_frame_sequencer.sv
// Frame-level controller for the Canny pipeline: latches geometry, gates W*H
// pixels in, drains them out. CANNY_FRAME_PAD_EN pads short frames with zeros.
module canny_frame_sequencer #(
    parameter int MAX_WIDTH  = 1920,
    parameter int MAX_HEIGHT = 1080,
    parameter int DATA_W     = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ctrl_valid,
    input  logic [15:0]              width_in,
    input  logic [15:0]              height_in,
    input  logic                     ctrl_busy,
    output logic                     ctrl_send,
    output logic [15:0]              width_out,
    output logic [15:0]              height_out,
    canny_frame_sequencer_if.slave   in_s,
    output logic                     pipe_wr_en,
    output logic [DATA_W-1:0]        pipe_din,
    input  logic                     pipe_full,
    input  logic                     pipe_empty,
    output logic                     pipe_rd_en,
    input  logic [7:0]               pipe_dout,
    canny_frame_sequencer_if.master  out_s,
    output logic                     frame_done,
    output logic [2:0]               err_status
);

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        STREAM,
        DISCARD,
`ifdef CANNY_FRAME_PAD_EN
        PAD,
`endif
        DRAIN
    } state_t;

    state_t state, next_state;

    logic [31:0]       target;
    logic [31:0]       in_cnt;
    logic [31:0]       out_cnt;
    logic              err_geom, err_long, err_short;
    logic              out_valid_q, out_eop_q;
    logic [DATA_W-1:0] out_data_q;

    logic geom_ok, geom_bad, set_long, set_short, trunc, frame_end, in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ctrl_send  = 1'b0;
        in_ready   = 1'b0;
        pipe_wr_en = 1'b0;
        pipe_din   = '0;
        geom_ok    = 1'b0;
        geom_bad   = 1'b0;
        set_long   = 1'b0;
        set_short  = 1'b0;
        trunc      = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_valid) begin
                    if (width_in != 16'd0 && width_in <= 16'(MAX_WIDTH) &&
                        height_in != 16'd0 && height_in <= 16'(MAX_HEIGHT)) begin
                        geom_ok    = 1'b1;
                        next_state = CTRL;
                    end else begin
                        geom_bad = 1'b1;
                    end
                end
            end
            CTRL: begin
                if (!ctrl_busy) begin
                    ctrl_send  = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                in_ready   = ~pipe_full;
                pipe_din   = in_s.data;
                pipe_wr_en = in_s.valid & ~pipe_full;
                if (pipe_wr_en) begin
                    if (in_cnt == target - 32'd1) begin
                        if (in_s.eop) begin
                            next_state = DRAIN;
                        end else begin
                            set_long   = 1'b1;
                            next_state = DISCARD;
                        end
                    end else if (in_s.eop) begin
                        set_short = 1'b1;
`ifdef CANNY_FRAME_PAD_EN
                        next_state = PAD;
`else
                        trunc      = 1'b1;
                        next_state = DRAIN;
`endif
                    end
                end
            end
            DISCARD: begin
                in_ready = 1'b1;
                if (in_s.valid && in_s.eop)
                    next_state = DRAIN;
            end
`ifdef CANNY_FRAME_PAD_EN
            PAD: begin
                pipe_wr_en = ~pipe_full;
                if (pipe_wr_en && in_cnt == target - 32'd1)
                    next_state = DRAIN;
            end
`endif
            DRAIN: begin
                // Done once every beat is popped and the last one has left the output register
                if (out_cnt == target && (!out_valid_q || out_s.ready)) begin
                    frame_end  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        pipe_rd_en = (state != IDLE) & ~pipe_empty & (~out_valid_q | out_s.ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_out   <= 16'(MAX_WIDTH);
            height_out  <= 16'(MAX_HEIGHT);
            target      <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            err_geom    <= 1'b0;
            err_long    <= 1'b0;
            err_short   <= 1'b0;
            out_valid_q <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (geom_ok) begin
                width_out  <= width_in;
                height_out <= height_in;
                target     <= 32'(width_in) * 32'(height_in);
            end
            if (geom_bad)
                err_geom <= 1'b1;
            if (set_long)
                err_long <= 1'b1;
            if (set_short)
                err_short <= 1'b1;
            if (frame_end) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (pipe_wr_en)
                    in_cnt <= in_cnt + 32'd1;
                if (trunc)
                    target <= in_cnt + 32'd1;
                if (pipe_rd_en)
                    out_cnt <= out_cnt + 32'd1;
            end
            if (pipe_rd_en) begin
                out_valid_q <= 1'b1;
                out_data_q  <= DATA_W'({3{pipe_dout}});
                out_eop_q   <= (out_cnt == target - 32'd1);
            end else if (out_s.ready) begin
                out_valid_q <= 1'b0;
                out_eop_q   <= 1'b0;
            end
        end
    end

    assign in_s.ready  = in_ready;
    assign out_s.valid = out_valid_q;
    assign out_s.data  = out_data_q;
    assign out_s.eop   = out_eop_q;
    assign frame_done  = frame_end;
    assign err_status  = {err_geom, err_long, err_short};

endmodule

// File: doc/canny_frame_sequencer.md
# canny_frame_sequencer

Frame-level controller for the Canny grayscale/filter pipeline between the VIP flow-control wrapper and the pipeline FIFOs. Latches frame geometry from VIP control packets, emits one control-packet send per frame, gates exactly width×height pixels into the pipeline, and drains the same count out with a correct end-of-video marker. Short and long input frames are handled without desynchronising the pipeline.

## Interface
- MAX_WIDTH, 1920, largest accepted width
- MAX_HEIGHT, 1080, largest accepted height
- DATA_W, 24, input/output beat width (3×8 RGB)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ctrl_valid  in  1  geometry strobe from VIP control decoder
- width_in, height_in  in  16 each  geometry from decoder
- ctrl_busy  in  1  VIP encoder busy
- ctrl_send  out  1  one-cycle request to encoder to send control packet
- width_out, height_out  out  16 each  latched geometry for encoder
- in_valid  in  1  input beat valid (= ~stall_in)
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  DATA_W  input pixel
- in_eop  in  1  end-of-video, qualified with in_valid on the last beat
- pipe_wr_en  out  1  pipeline input FIFO write
- pipe_din  out  DATA_W  pipeline input data
- pipe_full  in  1  pipeline input FIFO full
- pipe_empty  in  1  pipeline output FIFO empty (first-word-fall-through)
- pipe_rd_en  out  1  pipeline output FIFO pop
- pipe_dout  in  8  grayscale pixel, valid when ~pipe_empty
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready (= ~stall_out)
- out_data  out  DATA_W  {pipe_dout ×3}
- out_eop  out  1  end-of-video on final output beat
- frame_done  out  1  one-cycle pulse on frame completion
- err_status  out  3  sticky {err_geom, err_long, err_short}

## Operation
- States: IDLE, CTRL, STREAM, PAD (macro only), DISCARD, DRAIN.
- IDLE: on ctrl_valid, if 1≤width_in≤MAX_WIDTH and 1≤height_in≤MAX_HEIGHT latch geometry, target = W×H (32-bit), → CTRL; else set err_geom, stay. ctrl_valid outside IDLE ignored.
- CTRL: when ~ctrl_busy pulse ctrl_send one cycle, → STREAM.
- STREAM: in_ready = ~pipe_full; pipe_wr_en = in_valid & in_ready; pipe_din = in_data; in_cnt++ per write.
  - Accepted beat with in_cnt = target−1: with in_eop → DRAIN; without → DISCARD, set err_long.
  - Accepted beat with in_eop before target: set err_short; → PAD (macro) or DRAIN with target = in_cnt+1.
- DISCARD: in_ready = 1, pipe_wr_en = 0; drop beats until one with in_eop, → DRAIN.
- DRAIN: in_ready = 0; → IDLE when out_cnt reaches target and final beat accepted; frame_done pulses that cycle; counters clear.
- Output path (all non-IDLE states): pipe_rd_en = ~pipe_empty & (~out_valid | out_ready); registered out_data/out_valid; out_eop set with beat index target−1.
- in_ready = 0 in IDLE and CTRL.

## Timing
- Reset: all outputs 0 except width_out = 1920, height_out = 1080; state IDLE; err_status cleared (only by rst).
- ctrl_valid → ctrl_send: ≥2 cycles (IDLE→CTRL, then pulse), later while ctrl_busy.
- Input path combinational (0 latency); output register: 1 cycle from pop to out_valid.
- out_valid held with stable data/eop until out_ready.
- Simultaneous final input beat and output pops: both counted same cycle.
- rst mid-frame: immediate abort; the pipeline is reset by the same rst.

## Configuration
- CANNY_FRAME_PAD_EN defined: PAD state writes zero pixels (pipe_wr_en when ~pipe_full, in_ready = 0) until in_cnt = target, then DRAIN; output always W×H beats.
- Undefined: no PAD; short frame truncates target, output beat count equals received count.

## Test plan
- 4×2 frame, in_valid constant, out_ready = 1 -> one ctrl_send, 8 pipe writes, 8 out beats, out_eop on 8th, frame_done once, err_status = 0.
- 4×2 frame with pipe_full toggled and out_ready 50% -> no beat lost/duplicated, out_data = {g,g,g} in order.
- 4×2 frame, in_eop on beat 5 -> err_short; macro: 8 out beats (last 3 from zero inputs); no macro: 5 beats, eop on 5th.
- 4×2 frame, 11 input beats, in_eop on 11th -> 8 writes, 3 discarded, err_long, 8 out beats.
- ctrl_valid with width_in = 0 or 2000 -> err_geom, no ctrl_send, in_ready stays 0.
- rst asserted during STREAM at beat 3 -> outputs at reset values next edge; following 2×2 frame completes normally.
